divider_seq: RTL and testbench
==============================

# divider_seq

Sequential restoring divider for the 4-bit ALU, performing the inverse of the 3x4 array multiplier. It divides a 7-bit unsigned dividend, sized to a full multiplier product, by a 4-bit unsigned divisor. It produces a 7-bit quotient and a 4-bit remainder, one quotient bit per clock. It sits beside the multiplier in the ALU datapath and is driven by the ALU control through a start/busy/done handshake.

## Interface
- `DIVIDEND_W`, default 7: dividend and quotient width.
- `DIVISOR_W`, default 4: divisor and remainder width.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst` input, 1 bit: reset, asynchronous and active-high.
- `start` input, 1 bit: request a division; sampled only in IDLE.
- `dividend` input, DIVIDEND_W bits: unsigned dividend; sampled on the accepting edge.
- `divisor` input, DIVISOR_W bits: unsigned divisor; sampled on the accepting edge.
- `quotient` output, DIVIDEND_W bits: result quotient; held until the next accepted start.
- `remainder` output, DIVISOR_W bits: result remainder; held until the next accepted start.
- `busy` output, 1 bit: high in RUN and DONE.
- `done` output, 1 bit: one-cycle pulse marking the result as valid.
- `dz` output, 1 bit: divide-by-zero flag; valid while `done` is high.

## Operation
- States and transitions:
  - IDLE: start=1 goes to RUN.
  - RUN: stays in RUN until the step counter reaches its last step, then goes to DONE.
  - DONE: goes to IDLE unconditionally.
- Accept (IDLE with start=1):
  - Latch dividend into the shift register and divisor into the divisor register.
  - Clear the partial remainder (DIVISOR_W+1 bits).
  - Load the step counter with DIVIDEND_W-1.
- Each RUN step:
  - Form t = {pr[DIVISOR_W-1:0], dividend MSB}.
  - Shift the dividend register left.
  - If t ≥ divisor: pr = t − divisor and shift 1 into the quotient LSB.
  - Otherwise: pr = t and shift 0 into the quotient LSB.
  - Compare and subtract at DIVISOR_W+1 bits. The partial remainder never exceeds DIVISOR_W bits after subtraction.
- After DIVIDEND_W steps:
  - quotient = floor(dividend / divisor).
  - remainder = dividend mod divisor.
- Divisor = 0 with the natural algorithm: every compare succeeds, giving quotient = all ones (7'h7F) and remainder = dividend[3:0]. This is the defined result.
- start while busy=1 is ignored, including in the DONE cycle. There is no queuing.
- Reset, at any time including mid-RUN:
  - State goes to IDLE.
  - quotient, remainder, busy, done and dz all go to 0.
  - Internal registers are cleared.
  - A division in flight is lost and no done is produced.

## Timing
- Edge E0 samples start=1 in IDLE. busy is high from after E0.
- Edges E1..E7 perform the 7 steps. E7 also moves the state to DONE and registers the final quotient and remainder.
- done=1 for exactly one cycle, between E7 and E8. At E8 the state returns to IDLE and busy falls.
- Latency: done is visible 7 cycles after the accepting edge. Minimum issue interval is 9 cycles.
- Outputs are registered, with no combinational path from inputs to outputs.

## Configuration
- `DIVIDER_DZ_CHECK_EN`
  - Defined: at accept, if divisor == 0, skip RUN and go straight to DONE. done is high in the cycle after E0. quotient = 7'h7F, remainder = dividend[3:0], dz = 1.
  - Not defined: dz is tied 0, and zero divisors take the full 7-step run. They produce the same quotient and remainder values.

## Structure
- Shared package `alu_pkg`:
  - width constants DIVIDEND_W and DIVISOR_W, also used by the multiplier;
  - state encoding IDLE/RUN/DONE;
  - counter width $clog2(DIVIDEND_W).
- Sub-module `div_step`: one combinational compare/subtract cell.
  - Inputs: pr, next dividend bit, divisor.
  - Outputs: new pr, quotient bit.
- The top level holds the FSM, counter and registers.

## Test plan
- 105 / 7 → after 7 cycles done=1, quotient=15, remainder=0, dz=0, busy falls one cycle later.
- 127 / 15 → quotient=8, remainder=7. Follow with 90 / 4 → quotient=22, remainder=2. Also check 0 / 5 → quotient=0, remainder=0.
- 45 / 0:
  - With `DIVIDER_DZ_CHECK_EN`: done on the cycle after accept, quotient=7'h7F, remainder=13, dz=1.
  - Without it: done after 7 cycles with the same values and dz=0.
- start pulsed during RUN and during the DONE cycle with new operands → ignored; the first result is unchanged and no second done occurs.
- rst asserted mid-RUN, asynchronously between edges → all outputs 0 immediately. No done follows. A new start of 100 / 9 then yields quotient=11, remainder=1.
- Back-to-back: start held high continuously → a division is accepted every 9 cycles and each produces exactly one done pulse.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand widths, divider FSM states, step counter width.
package alu_pkg;

    localparam int unsigned DIVIDEND_W = 7;
    localparam int unsigned DIVISOR_W  = 4;
    localparam int unsigned CNT_W      = $clog2(DIVIDEND_W);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division cell: shift in the next dividend bit, compare, conditionally subtract.
module div_step #(
    parameter int unsigned DIVISOR_W = 4
) (
    input  logic [DIVISOR_W:0]   pr_i,
    input  logic                 bit_i,
    input  logic [DIVISOR_W-1:0] divisor_i,
    output logic [DIVISOR_W:0]   pr_c_o,
    output logic                 q_c_o
);

    logic [DIVISOR_W:0] t_c;
    logic [DIVISOR_W:0] dsr_ext_c;
    logic               pr_msb_unused;

    // After a restoring step the partial remainder fits in DIVISOR_W bits, so its MSB is never shifted out.
    assign pr_msb_unused = pr_i[DIVISOR_W];

    // Trial subtraction at DIVISOR_W+1 bits; a zero divisor always succeeds.
    always_comb begin
        t_c       = {pr_i[DIVISOR_W-1:0], bit_i};
        dsr_ext_c = {1'b0, divisor_i};
        q_c_o     = (t_c >= dsr_ext_c);
        pr_c_o    = q_c_o ? (t_c - dsr_ext_c) : t_c;
    end

endmodule

// File: rtl/divider_seq.sv
// Sequential restoring divider, one quotient bit per clock, start/busy/done handshake.
// Optional DIVIDER_DZ_CHECK_EN: zero divisor short-circuits to DONE and raises dz.
module divider_seq #(
    parameter int unsigned DIVIDEND_W = alu_pkg::DIVIDEND_W,
    parameter int unsigned DIVISOR_W  = alu_pkg::DIVISOR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  busy,
    output logic                  done,
    output logic                  dz
);

    import alu_pkg::*;

    localparam int unsigned CNT_LW = $clog2(DIVIDEND_W);

    div_state_e            state_q, state_d;
    logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
    logic [DIVISOR_W-1:0]  dsr_q, dsr_d;
    logic [DIVISOR_W:0]    pr_q, pr_d;
    logic [CNT_LW-1:0]     cnt_q, cnt_d;
    logic [DIVIDEND_W-1:0] quo_q, quo_d;
    logic [DIVISOR_W-1:0]  rem_q, rem_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  dz_q, dz_d;
    logic [DIVISOR_W:0]    step_pr_c;
    logic                  step_q_c;

    div_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .pr_i      (pr_q),
        .bit_i     (dvd_q[DIVIDEND_W-1]),
        .divisor_i (dsr_q),
        .pr_c_o    (step_pr_c),
        .q_c_o     (step_q_c)
    );

    // State and datapath registers; dvd_q doubles as the quotient shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dvd_q   <= '0;
            dsr_q   <= '0;
            pr_q    <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            pr_q    <= pr_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    // Next-state, datapath update and registered-output decode.
    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        pr_d    = pr_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dz_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dvd_d   = dividend;
                    dsr_d   = divisor;
                    pr_d    = '0;
                    cnt_d   = CNT_LW'(DIVIDEND_W - 1);
                    state_d = ST_RUN;
`ifdef DIVIDER_DZ_CHECK_EN
                    if (divisor == '0) begin
                        state_d = ST_DONE;
                        quo_d   = '1;
                        rem_d   = dividend[DIVISOR_W-1:0];
                        dz_d    = 1'b1;
                    end
`endif
                end
            end
            ST_RUN: begin
                dvd_d = {dvd_q[DIVIDEND_W-2:0], step_q_c};
                pr_d  = step_pr_c;
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    quo_d   = {dvd_q[DIVIDEND_W-2:0], step_q_c};
                    rem_d   = step_pr_c[DIVISOR_W-1:0];
                end else begin
                    cnt_d = cnt_q - CNT_LW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dz        = dz_q;

endmodule

// File: tb/tb_divider_seq.sv
// Bench for divider_seq: arithmetic reference model with per-cycle compare plus directed literal checks.
module tb_divider_seq;

`ifdef DIVIDER_DZ_CHECK_EN
    localparam bit DZ_EN = 1'b1;
`else
    localparam bit DZ_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [6:0] dividend;
    logic [3:0] divisor;
    logic [6:0] quotient;
    logic [3:0] remainder;
    logic       busy;
    logic       done;
    logic       dz;

    int checks = 0;
    int errors = 0;
    int dut_done_cnt = 0;

    // Model state
    bit m_active;
    bit m_dz;
    int m_cnt;
    int m_lat;
    int m_q;
    int m_r;
    int held_q;
    int held_r;

    always #5 clk = ~clk;

    divider_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .dz        (dz)
    );

    function automatic int ref_q(input int a, input int b);
        return (b == 0) ? 127 : a / b;
    endfunction

    function automatic int ref_r(input int a, input int b);
        return (b == 0) ? a % 16 : a % b;
    endfunction

    function automatic int lat_of(input int b);
        return (DZ_EN && b == 0) ? 0 : 7;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks accept edge, result latency and held outputs.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active <= 1'b0;
            m_dz     <= 1'b0;
            m_cnt    <= 0;
            m_lat    <= 0;
            m_q      <= 0;
            m_r      <= 0;
            held_q   <= 0;
            held_r   <= 0;
        end else if (!m_active) begin
            if (start) begin
                m_active <= 1'b1;
                m_cnt    <= 0;
                m_lat    <= lat_of(int'(divisor));
                m_q      <= ref_q(int'(dividend), int'(divisor));
                m_r      <= ref_r(int'(dividend), int'(divisor));
                m_dz     <= DZ_EN && (divisor == 4'd0);
                if (lat_of(int'(divisor)) == 0) begin
                    held_q <= ref_q(int'(dividend), int'(divisor));
                    held_r <= ref_r(int'(dividend), int'(divisor));
                end
            end
        end else begin
            m_cnt <= m_cnt + 1;
            if (m_cnt + 1 == m_lat) begin
                held_q <= m_q;
                held_r <= m_r;
            end
            if (m_cnt == m_lat) m_active <= 1'b0;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("busy", int'(busy), int'(m_active));
            chk("done", int'(done), int'(m_active && m_cnt == m_lat));
            chk("dz", int'(dz), int'(m_active && m_cnt == m_lat && m_dz));
            chk("quotient", int'(quotient), held_q);
            chk("remainder", int'(remainder), held_r);
            if (done) dut_done_cnt++;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (n >= 30) chk("wait_idle_timeout", n, 0);
    endtask

    task automatic run_div(input int a, input int b, input int eq, input int er);
        int n = 0;
        @(negedge clk);
        wait_idle();
        dividend = 7'(a);
        divisor  = 4'(b);
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, lat_of(b));
        chk("lit_quotient", int'(quotient), eq);
        chk("lit_remainder", int'(remainder), er);
        chk("lit_dz", int'(dz), int'(DZ_EN && b == 0));
        @(negedge clk);
        chk("busy_after_done", int'(busy), 0);
        chk("done_one_cycle", int'(done), 0);
    endtask

    initial begin
        int base;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        chk("rst_quotient", int'(quotient), 0);
        chk("rst_remainder", int'(remainder), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_dz", int'(dz), 0);
        rst = 1'b0;

        run_div(105, 7, 15, 0);

        // start pulses during RUN and during DONE must be ignored
        @(negedge clk);
        wait_idle();
        base     = dut_done_cnt;
        dividend = 7'd127;
        divisor  = 4'd15;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        dividend = 7'd3;
        divisor  = 4'd1;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && !done; i++) @(negedge clk);
        chk("ign_quotient", int'(quotient), 8);
        chk("ign_remainder", int'(remainder), 7);
        dividend = 7'd99;
        divisor  = 4'd2;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        chk("ign_done_count", dut_done_cnt - base, 1);
        chk("ign_busy", int'(busy), 0);
        chk("ign_held_quotient", int'(quotient), 8);

        run_div(90, 4, 22, 2);
        run_div(0, 5, 0, 0);
        run_div(45, 0, 127, 13);

        // asynchronous reset mid-run
        @(negedge clk);
        wait_idle();
        base     = dut_done_cnt;
        dividend = 7'd100;
        divisor  = 4'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_quotient", int'(quotient), 0);
        chk("arst_remainder", int'(remainder), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_dz", int'(dz), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("arst_no_done", dut_done_cnt - base, 0);
        run_div(100, 9, 11, 1);

        // back-to-back: start held high for 36 sampled edges gives 4 accepts
        @(negedge clk);
        wait_idle();
        base     = dut_done_cnt;
        dividend = 7'($urandom);
        divisor  = 4'($urandom_range(1, 15));
        start    = 1'b1;
        for (int i = 0; i < 36; i++) begin
            @(negedge clk);
            dividend = 7'($urandom);
            divisor  = 4'($urandom_range(1, 15));
        end
        start = 1'b0;
        repeat (12) @(negedge clk);
        chk("b2b_done_count", dut_done_cnt - base, 4);

        // randomized traffic, including zero divisors and start while busy
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            start    = ($urandom_range(0, 3) == 0);
            dividend = 7'($urandom);
            divisor  = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
        end
        start = 1'b0;
        @(negedge clk);
        wait_idle();
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
